// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states
// and the funct3 legality check used when a request is accepted.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} lsu_state_t;

  // Stores only have signed-size encodings; loads also allow the unsigned ones.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake and data-memory bus of the load/store unit.
// master: the requester/memory environment; slave: the load/store unit.
interface lsu_if #(
  parameter int WIDTH = 32
);

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;

  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;

  logic [WIDTH-1:0] mem_addr;
  logic             mem_write_en;
  logic [WIDTH-1:0] mem_write_data;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_write_en, mem_write_data
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_write_en, mem_write_data
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational data path of the load/store unit: extracts and extends load
// results from the word read at the access address, and merges SB/SH store
// data into that word so the memory can always be written four bytes at once.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] word,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] store_word
);

  // Load extract: byte/half from the low end of the word, sign or zero extended.
  always_comb begin
    load_data = '0;
    case (funct3)
      F3_B:    load_data = {{(WIDTH-8){word[7]}}, word[7:0]};
      F3_H:    load_data = {{(WIDTH-16){word[15]}}, word[15:0]};
      F3_W:    load_data = word;
      F3_BU:   load_data = {{(WIDTH-8){1'b0}}, word[7:0]};
      F3_HU:   load_data = {{(WIDTH-16){1'b0}}, word[15:0]};
      default: load_data = '0;
    endcase
  end

  // Store merge: only the low byte/half is replaced, upper bytes written back.
  always_comb begin
    store_word = word;
    case (funct3)
      F3_B:    store_word = {word[WIDTH-1:8], wdata[7:0]};
      F3_H:    store_word = {word[WIDTH-1:16], wdata[15:0]};
      F3_W:    store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between execute stage and byte-addressable memory.
// One request at a time: IDLE -> (RD) -> (WR) -> RESP -> IDLE.
// Define LSU_MISALIGN_TRAP_EN to report misaligned LH/LHU/SH/LW/SW as errors;
// otherwise misaligned accesses are carried out on the byte-addressed memory.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);

  // Highest start address whose four bytes still fit in the memory.
  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'(DEPTH - 4);

  lsu_state_t       state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic             req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic             mem_write_en_q, mem_write_en_d;
  logic [WIDTH-1:0] mem_write_data_q, mem_write_data_d;

  logic [WIDTH-1:0] load_data;
  logic [WIDTH-1:0] store_word;
  logic             req_oob;
  logic             req_bad_f3;
  logic             req_misalign;
  logic             req_err;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .funct3     (funct3_q),
    .word       (bus.mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Request errors are decided up front so a bad request never touches memory.
  assign req_oob    = bus.req_addr > LAST_ADDR;
  assign req_bad_f3 = !funct3_legal(bus.req_we, bus.req_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
  assign req_misalign =
      (((bus.req_funct3 == F3_H) || (bus.req_funct3 == F3_HU)) && bus.req_addr[0]) ||
      ((bus.req_funct3 == F3_W) && (bus.req_addr[1:0] != 2'b00));
`else
  assign req_misalign = 1'b0;
`endif
  assign req_err = req_oob || req_bad_f3 || req_misalign;

  // Next state and next registered outputs; outputs are pulses by default.
  always_comb begin
    state_d          = state_q;
    we_d             = we_q;
    funct3_d         = funct3_q;
    wdata_d          = wdata_q;
    addr_d           = addr_q;
    resp_valid_d     = 1'b0;
    resp_err_d       = 1'b0;
    resp_rdata_d     = '0;
    mem_write_en_d   = 1'b0;
    mem_write_data_d = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          wdata_d  = bus.req_wdata;
          addr_d   = bus.req_addr;
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
            // Full-word store needs no read of the old contents.
            state_d          = WR;
            mem_write_en_d   = 1'b1;
            mem_write_data_d = bus.req_wdata;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        if (we_q) begin
          // SB/SH: write back the captured word with the low bytes replaced.
          state_d          = WR;
          mem_write_en_d   = 1'b1;
          mem_write_data_d = store_word;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_data;
        end
      end
      WR: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State, latched request and registered outputs; reset aborts any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      we_q             <= 1'b0;
      funct3_q         <= 3'b000;
      wdata_q          <= '0;
      addr_q           <= '0;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      resp_err_q       <= 1'b0;
      resp_rdata_q     <= '0;
      mem_write_en_q   <= 1'b0;
      mem_write_data_q <= '0;
    end else begin
      state_q          <= state_d;
      we_q             <= we_d;
      funct3_q         <= funct3_d;
      wdata_q          <= wdata_d;
      addr_q           <= addr_d;
      req_ready_q      <= req_ready_d;
      resp_valid_q     <= resp_valid_d;
      resp_err_q       <= resp_err_d;
      resp_rdata_q     <= resp_rdata_d;
      mem_write_en_q   <= mem_write_en_d;
      mem_write_data_q <= mem_write_data_d;
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.resp_valid     = resp_valid_q;
  assign bus.resp_err       = resp_err_q;
  assign bus.resp_rdata     = resp_rdata_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_en   = mem_write_en_q;
  assign bus.mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte memory, a transaction-level
// reference model checked every cycle, and directed transactions with
// hand-computed results. Honours LSU_MISALIGN_TRAP_EN like the design.
module tb_load_store_unit;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.WIDTH(WIDTH)) bus ();

  load_store_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Initial memory image: pattern plus the bytes used by the directed tests.
  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h10: return 8'h80;
      'h11: return 8'h7F;
      'h12: return 8'h01;
      'h13: return 8'h02;
      'h14: return 8'h5A;
      'h15: return 8'hC3;
      'h20: return 8'h44;
      'h21: return 8'h33;
      'h22: return 8'h22;
      'h23: return 8'h11;
      default: return 8'((i * 7 + 3) % 256);
    endcase
  endfunction

  // Bench memory driven by the DUT, and the model's own copy.
  logic [7:0] mem     [0:DEPTH+3];
  logic [7:0] ref_mem [0:DEPTH-1];

  initial begin
    for (int i = 0; i < DEPTH + 4; i++) mem[i] = init_byte(i);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_byte(i);
  end

  always_comb begin
    bus.mem_rdata = '0;
    if (bus.mem_addr < 32'(DEPTH))
      for (int k = 0; k < 4; k++) bus.mem_rdata[8*k +: 8] = mem[int'(bus.mem_addr) + k];
  end

  always @(posedge clk) begin
    if (bus.mem_write_en && bus.mem_addr <= 32'(DEPTH - 4))
      for (int k = 0; k < 4; k++) mem[int'(bus.mem_addr) + k] <= bus.mem_write_data[8*k +: 8];
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        err;
    logic [1:0]  lat;    // cycles from accept to response
    logic [1:0]  wcyc;   // cycle of the memory write, 0 = none
    logic [31:0] rdata;
    logic [31:0] wdata;
    logic [31:0] addr;
  } txn_t;

  function automatic txn_t model_txn(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr, input logic [31:0] wd);
    txn_t        t;
    logic [31:0] word;
    logic [31:0] b;
    logic [31:0] h;
    logic        legal;
    int          size;
    t = '0;
    t.addr = addr;
    word = 32'd0;
    if (we) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    t.err = !legal || (addr > 32'(DEPTH - 4));
`ifdef LSU_MISALIGN_TRAP_EN
    if ((addr % 32'(size)) != 32'd0) t.err = 1'b1;
`endif
    if (!t.err)
      for (int k = 0; k < 4; k++) word = word + (32'(ref_mem[int'(addr) + k]) << (8 * k));
    b = word % 32'd256;
    h = word % 32'd65536;
    if (t.err) begin
      t.lat = 2'd1;
    end else if (!we) begin
      t.lat = 2'd2;
      case (f3)
        3'd0:    t.rdata = (b >= 32'd128) ? b - 32'd256 : b;
        3'd1:    t.rdata = (h >= 32'd32768) ? h - 32'd65536 : h;
        3'd4:    t.rdata = b;
        3'd5:    t.rdata = h;
        default: t.rdata = word;
      endcase
    end else if (f3 == 3'd2) begin
      t.lat = 2'd2; t.wcyc = 2'd1; t.wdata = wd;
    end else if (f3 == 3'd0) begin
      t.lat = 2'd3; t.wcyc = 2'd2; t.wdata = word - b + (wd % 32'd256);
    end else begin
      t.lat = 2'd3; t.wcyc = 2'd2; t.wdata = word - h + (wd % 32'd65536);
    end
    return t;
  endfunction

  txn_t        m_t;
  logic        m_active;
  logic [1:0]  m_age;
  logic [31:0] m_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_age    <= 2'd0;
      m_addr   <= 32'd0;
      m_t      <= '0;
    end else if (m_active) begin
      if (m_t.wcyc != 2'd0 && m_age == m_t.wcyc)
        for (int k = 0; k < 4; k++) ref_mem[int'(m_t.addr) + k] <= m_t.wdata[8*k +: 8];
      if (m_age == m_t.lat) m_active <= 1'b0;
      else                  m_age <= m_age + 2'd1;
    end else if (bus.req_valid) begin
      m_t      <= model_txn(bus.req_we, bus.req_funct3, bus.req_addr, bus.req_wdata);
      m_active <= 1'b1;
      m_age    <= 2'd1;
      m_addr   <= bus.req_addr;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic logic exp_rv = m_active && (m_age == m_t.lat);
      automatic logic exp_we = m_active && (m_t.wcyc != 2'd0) && (m_age == m_t.wcyc);
      check("cyc_req_ready", 32'(bus.req_ready), 32'(!m_active));
      check("cyc_resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
      check("cyc_mem_write_en", 32'(bus.mem_write_en), 32'(exp_we));
      check("cyc_mem_addr", bus.mem_addr, m_addr);
      if (exp_rv) begin
        check("cyc_resp_err", 32'(bus.resp_err), 32'(m_t.err));
        check("cyc_resp_rdata", bus.resp_rdata, m_t.rdata);
      end
      if (exp_we) check("cyc_mem_write_data", bus.mem_write_data, m_t.wdata);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic do_txn(input string name, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd, input int exp_lat,
                        input int exp_wcyc, input logic [31:0] exp_wd);
    int          lat;
    int          wcnt;
    int          wat;
    logic [31:0] wdat;
    logic [31:0] rd;
    logic        er;
    lat = 0; wcnt = 0; wat = 0; wdat = 32'd0; rd = 32'd0; er = 1'b0;
    @(negedge clk);
    check({name, "/ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    @(posedge clk);
    #1;
    // Junk on the request lines while busy must be ignored.
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFF0;
    bus.req_wdata  = 32'h5555_AAAA;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (bus.mem_write_en) begin wcnt++; wat = n; wdat = bus.mem_write_data; end
      if (bus.resp_valid) begin lat = n; rd = bus.resp_rdata; er = bus.resp_err; end
    end
    check({name, "/latency"}, 32'(lat), 32'(exp_lat));
    check({name, "/err"}, 32'(er), 32'(exp_err));
    check({name, "/rdata"}, rd, exp_rd);
    check({name, "/writes"}, 32'(wcnt), (exp_wcyc != 0) ? 32'd1 : 32'd0);
    if (exp_wcyc != 0) begin
      check({name, "/write_cycle"}, 32'(wat), 32'(exp_wcyc));
      check({name, "/write_data"}, wdat, exp_wd);
    end
    $display("txn %-10s we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> lat=%0d err=%0d rdata=0x%08h writes=%0d wdata=0x%08h",
             name, we, f3, addr, wd, lat, er, rd, wcnt, wdat);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst/req_ready", 32'(bus.req_ready), 32'd1);
    check("rst/resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst/resp_err", 32'(bus.resp_err), 32'd0);
    check("rst/mem_write_en", 32'(bus.mem_write_en), 32'd0);
    check("rst/resp_rdata", bus.resp_rdata, 32'd0);
    check("rst/mem_addr", bus.mem_addr, 32'd0);
    check("rst/mem_write_data", bus.mem_write_data, 32'd0);
    #2 rst_n = 1'b1;

    // Loads from bytes 80 7F 01 02 at 0x10.
    do_txn("LB_10",  1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFF_FF80, 2, 0, 32'h0);
    do_txn("LBU_10", 1'b0, 3'b100, 32'h10, 32'h0, 1'b0, 32'h0000_0080, 2, 0, 32'h0);
    do_txn("LH_10",  1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'h0000_7F80, 2, 0, 32'h0);
    do_txn("LHU_10", 1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000_7F80, 2, 0, 32'h0);
    do_txn("LW_10",  1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h0201_7F80, 2, 0, 32'h0);
    // Read-modify-write stores over word 0x11223344 at 0x20.
    do_txn("SB_20",  1'b1, 3'b000, 32'h20, 32'hAABB_CCDD, 1'b0, 32'h0, 3, 2, 32'h1122_33DD);
    do_txn("LW_20a", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h1122_33DD, 2, 0, 32'h0);
    do_txn("SH_20",  1'b1, 3'b001, 32'h20, 32'h1234_BEEF, 1'b0, 32'h0, 3, 2, 32'h1122_BEEF);
    do_txn("LB_21",  1'b0, 3'b000, 32'h21, 32'h0, 1'b0, 32'hFFFF_FFBE, 2, 0, 32'h0);
    // Bounds: 0xFC is the last legal word address.
    do_txn("SW_FC",  1'b1, 3'b010, 32'hFC, 32'hCAFE_F00D, 1'b0, 32'h0, 2, 1, 32'hCAFE_F00D);
    do_txn("LW_FC",  1'b0, 3'b010, 32'hFC, 32'h0, 1'b0, 32'hCAFE_F00D, 2, 0, 32'h0);
    do_txn("SW_FD",  1'b1, 3'b010, 32'hFD, 32'h1111_1111, 1'b1, 32'h0, 1, 0, 32'h0);
    do_txn("LB_100", 1'b0, 3'b000, 32'h100, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0);
    // Illegal funct3.
    do_txn("LD_F3_3", 1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0);
    do_txn("ST_F3_4", 1'b1, 3'b100, 32'h30, 32'h1, 1'b1, 32'h0, 1, 0, 32'h0);
    // Misaligned accesses.
`ifdef LSU_MISALIGN_TRAP_EN
    do_txn("LW_12",  1'b0, 3'b010, 32'h12, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0);
    do_txn("LH_11",  1'b0, 3'b001, 32'h11, 32'h0, 1'b1, 32'h0, 1, 0, 32'h0);
`else
    do_txn("LW_12",  1'b0, 3'b010, 32'h12, 32'h0, 1'b0, 32'hC35A_0201, 2, 0, 32'h0);
    do_txn("LH_11",  1'b0, 3'b001, 32'h11, 32'h0, 1'b0, 32'h0000_017F, 2, 0, 32'h0);
`endif

    // Reset while an SH sits in RD: no write, no response, ready after release.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h0000_DEAD;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("abort/req_ready", 32'(bus.req_ready), 32'd1);
    begin
      int wr_seen;
      int rv_seen;
      wr_seen = 0; rv_seen = 0;
      for (int n = 0; n < 4; n++) begin
        if (bus.mem_write_en) wr_seen++;
        if (bus.resp_valid) rv_seen++;
        @(negedge clk);
      end
      check("abort/writes", 32'(wr_seen), 32'd0);
      check("abort/responses", 32'(rv_seen), 32'd0);
      $display("txn %-10s we=1 f3=1 addr=0x00000020 aborted by reset -> writes=%0d responses=%0d",
               "SH_abort", wr_seen, rv_seen);
    end
    do_txn("LW_20b", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h1122_BEEF, 2, 0, 32'h0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
